// File: rtl/kitt_scan_sequencer.sv
// kitt_scan_sequencer: KITT scanner sequencing - speed prescaler, position counter, bounce/wrap scan FSM.
// Optional macro KITT_TRAIL_EN adds a PWM-dimmed two-LED trail behind the head.
`default_nettype none

module kitt_scan_sequencer #(
  parameter int N_LEDS      = 8,
  parameter int BASE_DIV    = 1_000_000,
  parameter int DWELL_TICKS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              mode,
  input  logic [3:0]        speed_sel,
  output logic [N_LEDS-1:0] leds,
  output logic [2:0]        pos,
  output logic              dir,
  output logic              step,
  output logic              busy
);

  localparam int PW = 4 + $clog2(BASE_DIV) + 1;
  localparam int DW = $clog2(DWELL_TICKS + 2);
  localparam logic [2:0]        LAST   = 3'(N_LEDS - 1);
  localparam logic [PW-1:0]     BASE_P = PW'(BASE_DIV);
  localparam logic [N_LEDS-1:0] ONE    = {{(N_LEDS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SCAN_UP, SCAN_DN, DWELL} state_t;

  state_t            state, state_nx;
  logic [PW-1:0]     div_cnt, div_nx, period, period_nx, new_period;
  logic [DW-1:0]     dwell_cnt, dwell_nx;
  logic [2:0]        pos_nx, pos_inc;
  logic              dir_nx, moved, tick, busy_nx;
  logic [N_LEDS-1:0] leds_nx;

  assign new_period = (PW'(speed_sel) + PW'(1)) * BASE_P;
  assign pos_inc    = (pos == LAST) ? 3'd0 : pos + 3'd1;
  assign tick       = (state != IDLE) && (div_cnt == period - PW'(1));
  assign busy_nx    = (state_nx != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      period    <= BASE_P;
      dwell_cnt <= '0;
      pos       <= 3'd0;
      dir       <= 1'b0;
      step      <= 1'b0;
      busy      <= 1'b0;
      leds      <= '0;
    end else begin
      state     <= state_nx;
      div_cnt   <= div_nx;
      period    <= period_nx;
      dwell_cnt <= dwell_nx;
      pos       <= pos_nx;
      dir       <= dir_nx;
      step      <= moved;
      busy      <= busy_nx;
      leds      <= leds_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    div_nx    = div_cnt;
    period_nx = period;
    dwell_nx  = dwell_cnt;
    pos_nx    = pos;
    dir_nx    = dir;
    moved     = 1'b0;
    if (state == IDLE) begin
      pos_nx = 3'd0;
      dir_nx = 1'b0;
      div_nx = '0;
      if (run) begin
        state_nx  = SCAN_UP;
        period_nx = new_period;
      end
    end else if (!run) begin
      // Abort wins over a coincident tick, so no step pulse is produced.
      state_nx = IDLE;
      pos_nx   = 3'd0;
      dir_nx   = 1'b0;
      div_nx   = '0;
    end else if (tick) begin
      div_nx    = '0;
      period_nx = new_period;
      if (mode && state != SCAN_UP) begin
        state_nx = SCAN_UP;
        dir_nx   = 1'b0;
        pos_nx   = pos_inc;
        moved    = 1'b1;
      end else begin
        case (state)
          SCAN_UP: begin
            if (pos < LAST || mode) begin
              pos_nx = pos_inc;
              moved  = 1'b1;
            end else if (DWELL_TICKS > 0) begin
              state_nx = DWELL;
              dwell_nx = '0;
            end else begin
              state_nx = SCAN_DN;
              dir_nx   = 1'b1;
              pos_nx   = pos - 3'd1;
              moved    = 1'b1;
            end
          end
          SCAN_DN: begin
            if (pos > 3'd0) begin
              pos_nx = pos - 3'd1;
              moved  = 1'b1;
            end else if (DWELL_TICKS > 0) begin
              state_nx = DWELL;
              dwell_nx = '0;
            end else begin
              state_nx = SCAN_UP;
              dir_nx   = 1'b0;
              pos_nx   = 3'd1;
              moved    = 1'b1;
            end
          end
          default: begin
            if (dwell_cnt + DW'(1) == DW'(DWELL_TICKS)) begin
              dir_nx   = ~dir;
              moved    = 1'b1;
              state_nx = dir ? SCAN_UP : SCAN_DN;
              pos_nx   = dir ? pos + 3'd1 : pos - 3'd1;
            end else begin
              dwell_nx = dwell_cnt + DW'(1);
            end
          end
        endcase
      end
    end else begin
      div_nx = div_cnt + PW'(1);
    end
  end

`ifdef KITT_TRAIL_EN
  localparam logic signed [4:0] NL = 5'(N_LEDS);

  logic [1:0]        pwm, pwm_nx;
  logic              mode_r, mode_nx;
  logic signed [4:0] stepv, t1, t2;

  // Trail taps outside the strip are dropped in bounce mode and folded back in wrap mode.
  function automatic logic [N_LEDS-1:0] trail_bit(input logic signed [4:0] p, input logic wrap);
    logic signed [4:0] q;
    q         = p;
    trail_bit = '0;
    if (wrap) begin
      if (q < 5'sd0) q = q + NL;
      else if (q >= NL) q = q - NL;
      trail_bit = ONE << q[2:0];
    end else if (q >= 5'sd0 && q < NL) begin
      trail_bit = ONE << q[2:0];
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm    <= 2'd0;
      mode_r <= 1'b0;
    end else begin
      pwm    <= pwm_nx;
      mode_r <= mode_nx;
    end
  end

  always_comb begin
    mode_nx = mode_r;
    if (run && (state == IDLE || tick)) mode_nx = mode;
    pwm_nx = busy_nx ? pwm + 2'd1 : 2'd0;
    stepv  = dir_nx ? 5'sd1 : -5'sd1;
    t1     = $signed({2'b00, pos_nx}) + stepv;
    t2     = t1 + stepv;
  end
`endif

  always_comb begin
    leds_nx = '0;
    if (busy_nx) begin
      leds_nx = ONE << pos_nx;
`ifdef KITT_TRAIL_EN
      if (pwm_nx < 2'd2)  leds_nx = leds_nx | trail_bit(t1, mode_nx);
      if (pwm_nx == 2'd0) leds_nx = leds_nx | trail_bit(t2, mode_nx);
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_kitt_scan_sequencer.sv
// tb_kitt_scan_sequencer: directed self-checking bench for kitt_scan_sequencer (BASE_DIV=4, DWELL_TICKS=2).
`default_nettype none

module tb_kitt_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] speed_sel = 4'd0;
  logic [7:0] leds;
  logic [2:0] pos;
  logic       dir, step, busy;

  int checks = 0;
  int failures = 0;

  kitt_scan_sequencer #(.N_LEDS(8), .BASE_DIV(4), .DWELL_TICKS(2)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mode(mode), .speed_sel(speed_sel),
    .leds(leds), .pos(pos), .dir(dir), .step(step), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // With the trail enabled only the head bit is predictable from pos alone.
  function automatic logic [7:0] lv(input logic [7:0] l, input logic [7:0] e);
`ifdef KITT_TRAIL_EN
    return l & e;
`else
    return l;
`endif
  endfunction

  function automatic void bounce_exp(input int k, output logic [2:0] p, output logic d);
    if (k < 28)      begin p = 3'(k / 4);            d = 1'b0; end
    else if (k < 40) begin p = 3'd7;                 d = 1'b0; end
    else if (k < 64) begin p = 3'(6 - (k - 40) / 4); d = 1'b1; end
    else if (k < 76) begin p = 3'd0;                 d = 1'b1; end
    else             begin p = 3'd1;                 d = 1'b0; end
  endfunction

  task automatic test_reset();
    cyc(1);
    checks++;
    if ({busy, pos, dir, step, leds} !== 14'd0) begin
      failures++;
      $display("FAIL reset_hold got busy=%b pos=%0d dir=%b step=%b leds=%h want all zero", busy, pos, dir, step, leds);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      checks++;
      if ({busy, pos, dir, step, leds} !== 14'd0) begin
        failures++;
        $display("FAIL idle k=%0d got busy=%b pos=%0d dir=%b step=%b leds=%h want all zero", k, busy, pos, dir, step, leds);
      end
    end
  endtask

  task automatic test_bounce();
    logic [2:0] ep, prevp;
    logic       ed, es;
    mode = 1'b0; speed_sel = 4'd0; run = 1'b1;
    prevp = 3'd0;
    for (int k = 0; k <= 76; k++) begin
      cyc(1);
      bounce_exp(k, ep, ed);
      es = (k > 0) && (ep != prevp);
      prevp = ep;
      checks++;
      if ({busy, pos, dir, step, lv(leds, 8'd1 << ep)} !== {1'b1, ep, ed, es, 8'd1 << ep}) begin
        failures++;
        $display("FAIL bounce k=%0d got busy=%b pos=%0d dir=%b step=%b leds=%h want busy=1 pos=%0d dir=%b step=%b leds=%h",
                 k, busy, pos, dir, step, leds, ep, ed, es, 8'd1 << ep);
      end
    end
  endtask

  task automatic test_abort();
    cyc(30);
    checks++;
    if ({busy, pos, dir, step} !== {1'b1, 3'd7, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL abort_pre got busy=%b pos=%0d dir=%b step=%b want busy=1 pos=7 dir=0 step=0", busy, pos, dir, step);
    end
    run = 1'b0;
    cyc(1);
    checks++;
    if ({busy, pos, dir, step, leds} !== 14'd0) begin
      failures++;
      $display("FAIL abort_idle got busy=%b pos=%0d dir=%b step=%b leds=%h want all zero", busy, pos, dir, step, leds);
    end
    run = 1'b1;
    cyc(1);
    checks++;
    if ({busy, pos, dir, step, lv(leds, 8'h01)} !== {1'b1, 3'd0, 1'b0, 1'b0, 8'h01}) begin
      failures++;
      $display("FAIL restart got busy=%b pos=%0d dir=%b step=%b leds=%h want busy=1 pos=0 dir=0 step=0 leds=01", busy, pos, dir, step, leds);
    end
    cyc(4);
    checks++;
    if ({pos, dir, step, lv(leds, 8'h02)} !== {3'd1, 1'b0, 1'b1, 8'h02}) begin
      failures++;
      $display("FAIL restart_step got pos=%0d dir=%b step=%b leds=%h want pos=1 dir=0 step=1 leds=02", pos, dir, step, leds);
    end
  endtask

  task automatic test_wrap_speed();
    logic [2:0] ep;
    logic       es;
    run = 1'b0;
    cyc(2);
    mode = 1'b1; speed_sel = 4'd3; run = 1'b1;
    for (int k = 0; k <= 152; k++) begin
      cyc(1);
      if (k < 144) begin
        ep = 3'((k / 16) % 8);
        es = (k > 0) && (k % 16 == 0);
      end else begin
        ep = 3'(1 + (k - 144) / 4);
        es = ((k - 144) % 4 == 0);
      end
      checks++;
      if ({busy, pos, dir, step, lv(leds, 8'd1 << ep)} !== {1'b1, ep, 1'b0, es, 8'd1 << ep}) begin
        failures++;
        $display("FAIL wrap k=%0d got busy=%b pos=%0d dir=%b step=%b leds=%h want busy=1 pos=%0d dir=0 step=%b leds=%h",
                 k, busy, pos, dir, step, leds, ep, es, 8'd1 << ep);
      end
      if (k == 133) speed_sel = 4'd0;
    end
  endtask

  task automatic test_async_reset();
    cyc(8);
    checks++;
    if ({busy, pos, step} !== {1'b1, 3'd5, 1'b1}) begin
      failures++;
      $display("FAIL areset_pre got busy=%b pos=%0d step=%b want busy=1 pos=5 step=1", busy, pos, step);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, pos, dir, step, leds} !== 14'd0) begin
      failures++;
      $display("FAIL areset got busy=%b pos=%0d dir=%b step=%b leds=%h want all zero", busy, pos, dir, step, leds);
    end
    #2 rst_n = 1'b1;
    cyc(1);
    checks++;
    if ({busy, pos, dir, step, lv(leds, 8'h01)} !== {1'b1, 3'd0, 1'b0, 1'b0, 8'h01}) begin
      failures++;
      $display("FAIL areset_restart got busy=%b pos=%0d dir=%b step=%b leds=%h want busy=1 pos=0 dir=0 step=0 leds=01", busy, pos, dir, step, leds);
    end
  endtask

`ifdef KITT_TRAIL_EN
  task automatic test_trail();
    int b3, b2, b1, stray;
    b3 = 0; b2 = 0; b1 = 0; stray = 0;
    run = 1'b0;
    cyc(2);
    mode = 1'b0; speed_sel = 4'd0; run = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cyc(1);
      if (k < 4) begin
        checks++;
        if (leds !== 8'h01) begin
          failures++;
          $display("FAIL trail_pos0 k=%0d got leds=%h want 01", k, leds);
        end
      end
      if (k >= 12) begin
        b3 += int'(leds[3]);
        b2 += int'(leds[2]);
        b1 += int'(leds[1]);
        if ((leds & 8'hF1) != 8'h00) stray++;
      end
    end
    checks++;
    if ({b3, b2, b1, stray} !== {32'd4, 32'd2, 32'd1, 32'd0}) begin
      failures++;
      $display("FAIL trail_pos3 got bit3=%0d bit2=%0d bit1=%0d stray=%0d want 4 2 1 0", b3, b2, b1, stray);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bounce();
    test_abort();
    test_wrap_speed();
    test_async_reset();
`ifdef KITT_TRAIL_EN
    test_trail();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
